// File: rtl/pe_pingpong_array_if.sv
// Load / control / psum-drain bundle between the GBF, the PE array and the writeback path.
// The array itself uses the slave modport; the GBF/controller side uses master.
interface pe_pingpong_array_if #(
    parameter int ROW               = 4,
    parameter int COL               = 4,
    parameter int ROW_BITWIDTH      = 2,
    parameter int OUT_BITWIDTH      = 32,
    parameter int RF_ADDR_BITWIDTH  = 2,
    parameter int GBF_DATA_BITWIDTH = 512
) ();
    logic                          ld_valid;
    logic                          ld_ready;
    logic                          ld_is_wgt;
    logic [RF_ADDR_BITWIDTH-1:0]   ld_addr;
    logic [GBF_DATA_BITWIDTH-1:0]  ld_data;
    logic [5*ROW*COL-1:0]          ld_sel;
    logic [ROW*COL-1:0]            ld_pe_en;
    logic                          ld_last;
    logic                          start;
    logic [RF_ADDR_BITWIDTH:0]     len;
    logic                          mac_mode;
    logic                          busy;
    logic                          done;
    logic                          out_valid;
    logic                          out_ready;
    logic [ROW_BITWIDTH-1:0]       out_row;
    logic [COL*OUT_BITWIDTH-1:0]   out_data;

    modport master (
        output ld_valid, ld_is_wgt, ld_addr, ld_data, ld_sel, ld_pe_en, ld_last,
        output start, len, mac_mode, out_ready,
        input  ld_ready, busy, done, out_valid, out_row, out_data
    );

    modport slave (
        input  ld_valid, ld_is_wgt, ld_addr, ld_data, ld_sel, ld_pe_en, ld_last,
        input  start, len, mac_mode, out_ready,
        output ld_ready, busy, done, out_valid, out_row, out_data
    );
endinterface

// File: rtl/pe_pingpong_array.sv
// ROW x COL MAC array with double-buffered actv/wgt register files: the GBF fills one bank
// while the array runs a len-cycle MAC loop on the other, then drains psums one row at a time.
module pe_pingpong_array #(
    parameter int ROW               = 4,
    parameter int COL               = 4,
    parameter int ROW_BITWIDTH      = 2,
    parameter int IN_BITWIDTH       = 16,
    parameter int OUT_BITWIDTH      = 32,
    parameter int RF_ADDR_BITWIDTH  = 2,
    parameter int RF_DEPTH          = 4,
    parameter int GBF_DATA_BITWIDTH = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    pe_pingpong_array_if.slave   bus
);

    localparam int LANES         = GBF_DATA_BITWIDTH / IN_BITWIDTH;
    localparam int SEL_BITWIDTH  = 5;
    localparam int PROD_BITWIDTH = 2 * IN_BITWIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                         state_reg, state_next;
    logic                           ld_bank_reg;
    logic                           comp_bank_reg;
    logic [1:0]                     bank_full_reg;
    logic [RF_ADDR_BITWIDTH-1:0]    cnt_reg;
    logic [RF_ADDR_BITWIDTH:0]      len_reg;
    logic [ROW_BITWIDTH-1:0]        row_reg;
    logic                           done_reg;

    logic                           ld_ready_int;
    logic                           ld_fire;
    logic                           start_fire;
    logic                           acc_clr;
    logic                           acc_en;
    logic                           row_fire;
    logic                           drain_last;

    logic [IN_BITWIDTH-1:0]                       lane_data [LANES];
    logic [ROW-1:0][COL-1:0][OUT_BITWIDTH-1:0]    acc_flat;

    // The load bank is only ever the bank not being computed on, so a beat can land any time.
    assign ld_ready_int = ~bank_full_reg[ld_bank_reg];
    assign ld_fire      = bus.ld_valid & ld_ready_int;

    genvar gi, gj;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_data[gi] = bus.ld_data[gi*IN_BITWIDTH +: IN_BITWIDTH];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        start_fire = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        row_fire   = 1'b0;
        drain_last = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && bank_full_reg[ld_bank_reg]) begin
                    start_fire = 1'b1;
                    acc_clr    = ~bus.mac_mode;
                    state_next = (bus.len == '0) ? DRAIN : COMPUTE;
                end
            end
            COMPUTE: begin
                acc_en = 1'b1;
                if ({1'b0, cnt_reg} == len_reg - 1'b1) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    row_fire = 1'b1;
                    if (row_reg == ROW_BITWIDTH'(ROW - 1)) begin
                        drain_last = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ld_bank_reg   <= 1'b0;
            comp_bank_reg <= 1'b0;
            bank_full_reg <= 2'b00;
            cnt_reg       <= '0;
            len_reg       <= '0;
            row_reg       <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= drain_last;
            if (start_fire) begin
                comp_bank_reg <= ld_bank_reg;
                ld_bank_reg   <= ~ld_bank_reg;
                cnt_reg       <= '0;
                len_reg       <= bus.len;
                row_reg       <= '0;
            end else if (acc_en) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (row_fire) begin
                row_reg <= drain_last ? '0 : row_reg + 1'b1;
            end
            // Set and release always hit different banks: ld_bank != comp_bank while draining.
            if (ld_fire && bus.ld_last) begin
                bank_full_reg[ld_bank_reg] <= 1'b1;
            end
            if (drain_last) begin
                bank_full_reg[comp_bank_reg] <= 1'b0;
            end
        end
    end

    generate
        for (gi = 0; gi < ROW; gi++) begin : g_row
            for (gj = 0; gj < COL; gj++) begin : g_col
                localparam int PE = gi * COL + gj;

                logic [IN_BITWIDTH-1:0]           actv_rf [2][RF_DEPTH];
                logic [IN_BITWIDTH-1:0]           wgt_rf  [2][RF_DEPTH];
                logic [SEL_BITWIDTH-1:0]          sel;
                logic [IN_BITWIDTH-1:0]           wr_data;
                logic signed [IN_BITWIDTH-1:0]    actv_rd;
                logic signed [IN_BITWIDTH-1:0]    wgt_rd;
                logic signed [PROD_BITWIDTH-1:0]  actv_ext;
                logic signed [PROD_BITWIDTH-1:0]  wgt_ext;
                logic signed [PROD_BITWIDTH-1:0]  prod;
                logic signed [OUT_BITWIDTH-1:0]   prod_ext;
                logic signed [OUT_BITWIDTH-1:0]   acc_reg;

                assign sel     = bus.ld_sel[SEL_BITWIDTH*PE +: SEL_BITWIDTH];
                assign wr_data = lane_data[sel];

                always_ff @(posedge clk) begin
                    if (ld_fire && bus.ld_pe_en[PE]) begin
                        if (bus.ld_is_wgt) begin
                            wgt_rf[ld_bank_reg][bus.ld_addr] <= wr_data;
                        end else begin
                            actv_rf[ld_bank_reg][bus.ld_addr] <= wr_data;
                        end
                    end
                end

                // Operands are widened before the multiply so the full signed product is kept;
                // the size cast then sign-extends or truncates it to the accumulator width.
                assign actv_rd  = actv_rf[comp_bank_reg][cnt_reg];
                assign wgt_rd   = wgt_rf[comp_bank_reg][cnt_reg];
                assign actv_ext = PROD_BITWIDTH'(actv_rd);
                assign wgt_ext  = PROD_BITWIDTH'(wgt_rd);
                assign prod     = actv_ext * wgt_ext;
                assign prod_ext = OUT_BITWIDTH'(prod);

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        acc_reg <= '0;
                    end else if (acc_clr) begin
                        acc_reg <= '0;
                    end else if (acc_en) begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                end

                assign acc_flat[gi][gj] = acc_reg;
            end
        end
    endgenerate

    assign bus.ld_ready  = ld_ready_int;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.out_valid = (state_reg == DRAIN);
    assign bus.out_row   = row_reg;
    assign bus.out_data  = (state_reg == DRAIN) ? acc_flat[row_reg] : '0;

endmodule
